// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: word stores into a small TX FIFO,
// drained by a baud-rate FSM onto o_txd. Register window is 16 bytes at BASE_ADDR.
package riscv;
  typedef enum logic [2:0] {
    NONE, LOAD_BYTE, LOAD_HALF, LOAD_WORD, STORE_BYTE, STORE_HALF, STORE_WORD
  } mem_op_t;
endpackage

module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  riscv::mem_op_t i_dmem_op,
  input  logic [31:0]    i_dmem_addr,
  input  logic [31:0]    i_dmem_wdata,
  output logic [31:0]    o_dmem_rdata,
  output logic           o_dmem_error,
  output logic           o_txd,
  output logic           o_busy
);
  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]    FULL_CNT = FIFO_DEPTH[AW:0];

  // IDLE: line high, wait for data | START: low | DATA: 8 bits LSB first | STOP: high, may chain
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [15:0]   r_div, r_timer;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit;
  logic          r_txd, r_busy;
  logic [31:0]   r_rdata;
  logic          r_error;

  logic        w_sel, w_err, w_load, w_store, w_push_req, w_push, w_pop;
  logic        w_full, w_empty, w_bit_done, w_reload, w_txd, w_unused;
  logic [1:0]  w_off;
  logic [15:0] w_period;
  logic [31:0] w_rd_mux;

  assign w_off   = i_dmem_addr[3:2];
  assign w_sel   = (i_dmem_addr[31:4] == BASE_ADDR[31:4]) && (i_dmem_op != riscv::NONE);
  assign w_err   = w_sel && (!(i_dmem_op == riscv::LOAD_WORD || i_dmem_op == riscv::STORE_WORD)
                             || (i_dmem_addr[1:0] != 2'd0) || (w_off == 2'd3));
  assign w_load  = w_sel && !w_err && (i_dmem_op == riscv::LOAD_WORD);
  assign w_store = w_sel && !w_err && (i_dmem_op == riscv::STORE_WORD);

  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push_req = w_store && (w_off == 2'd0);
  assign w_push     = w_push_req && !w_full;
  assign w_period   = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bit_done = (r_timer == 16'd0);
  assign w_unused   = ^i_dmem_wdata[31:16];

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_START;
      S_START: if (w_bit_done) w_next = S_DATA;
      S_DATA:  if (w_bit_done && (r_bit == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_bit_done) w_next = w_empty ? S_IDLE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_txd    = 1'b1;
    w_pop    = 1'b0;
    w_reload = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop    = !w_empty;
        w_reload = !w_empty;
      end
      S_START: begin
        w_txd    = 1'b0;
        w_reload = w_bit_done;
      end
      S_DATA: begin
        w_txd    = r_shift[0];
        w_reload = w_bit_done;
      end
      S_STOP: begin
        w_pop    = w_bit_done && !w_empty;
        w_reload = w_bit_done && !w_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timer <= 16'd0;
      r_shift <= 8'd0;
      r_bit   <= 3'd0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_txd  <= w_txd;
      r_busy <= (r_state != S_IDLE) || !w_empty;
      // Period is captured per bit, so divisor writes land on the next bit boundary.
      if (w_reload)        r_timer <= w_period - 16'd1;
      else if (!w_bit_done) r_timer <= r_timer - 16'd1;
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr];
        r_bit   <= 3'd0;
      end else if ((r_state == S_DATA) && w_bit_done) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dmem_wdata[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_div      <= DIV_RESET;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_push_req && w_full)
        r_overflow <= 1'b1;
      else if (w_store && (w_off == 2'd1) && i_dmem_wdata[3])
        r_overflow <= 1'b0;
      if (w_store && (w_off == 2'd2)) r_div <= i_dmem_wdata[15:0];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      2'd1:    w_rd_mux = {16'd0, 8'(r_count), 4'd0, r_overflow, w_empty, w_full, r_busy};
      2'd2:    w_rd_mux = {16'd0, r_div};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      r_rdata <= w_load ? w_rd_mux : '0;
      r_error <= w_err;
    end
  end

  assign o_dmem_rdata = r_rdata;
  assign o_dmem_error = r_error;
  assign o_txd        = r_txd;
  assign o_busy       = r_busy;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: bus responses and serial frames are
// queued at stimulus time and checked by independent monitors.
module tb_mmio_uart_tx;
  import riscv::*;

  localparam logic [31:0] BASE = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        reset;
  mem_op_t     op;
  logic [31:0] addr, wdata, rdata;
  logic        err, txd, busy;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd4)) dut (
    .i_clk(clk), .i_reset(reset), .i_dmem_op(op), .i_dmem_addr(addr),
    .i_dmem_wdata(wdata), .o_dmem_rdata(rdata), .o_dmem_error(err),
    .o_txd(txd), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit mon_quiet = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
    string       name;
  } bus_exp_t;

  typedef struct {
    logic [7:0]       data;
    bit               b2b;
    int               start;
    int               nseg;
    logic [9:0][15:0] per;
  } frame_t;

  bus_exp_t bq[$];
  frame_t   fq[$];

  function automatic frame_t mk(input logic [7:0] d, input bit b2b, input int start,
                                input int nseg, input int p0, input int prest);
    frame_t f;
    f.data = d; f.b2b = b2b; f.start = start; f.nseg = nseg;
    for (int i = 0; i < 10; i++) f.per[i] = (i == 0) ? 16'(p0) : 16'(prest);
    return f;
  endfunction

  task automatic bus(input mem_op_t o, input logic [31:0] a, input logic [31:0] w,
                     input logic [31:0] er, input logic ee, input string name);
    bus_exp_t e;
    @(negedge clk);
    op = o; addr = a; wdata = w;
    last_cyc = cyc + 1;
    e.due = cyc + 1; e.rd = er; e.er = ee; e.name = name;
    bq.push_back(e);
    @(posedge clk);
    #1;
    op = NONE; addr = '0; wdata = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Bus response monitor
  initial begin
    bus_exp_t e;
    forever begin
      @(negedge clk);
      if (bq.size() > 0 && bq[0].due == cyc) begin
        e = bq.pop_front();
        checks++;
        if (rdata !== e.rd || err !== e.er) begin
          failures++;
          $display("FAIL %s: got rdata=%h err=%b expected rdata=%h err=%b", e.name, rdata, err, e.rd, e.er);
        end
      end
    end
  end

  // Serial line monitor
  initial begin
    frame_t f;
    int     bad;
    logic   lvl;
    bit     pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        checks++;
        if (txd !== 1'b0) begin
          failures++;
          $display("FAIL frame_gap: got txd=%b expected 0 (cyc %0d)", txd, cyc);
        end
      end
      if (!mon_quiet && txd === 1'b0) begin
        if (fq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame: got txd=0 expected idle 1 (cyc %0d)", cyc);
          for (int k = 0; k < 2000 && txd !== 1'b1; k++) @(negedge clk);
        end else begin
          f = fq.pop_front();
          bad = 0;
          if (f.start != 0) begin
            checks++;
            if (cyc != f.start) begin
              failures++;
              $display("FAIL frame_start: got cyc %0d expected cyc %0d", cyc, f.start);
            end
          end
          for (int b = 0; b < f.nseg; b++) begin
            lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : f.data[b-1];
            for (int c = 0; c < int'(f.per[b]); c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (txd !== lvl) bad++;
            end
          end
          checks++;
          if (bad != 0) begin
            failures++;
            $display("FAIL frame_bits data=%h: got %0d wrong cycles expected 0", f.data, bad);
          end
          if (fq.size() > 0 && fq[0].b2b) pend = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    failures++;
    $display("FAIL watchdog: got cyc %0d expected finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    int          bad;
    logic [7:0]  t3 [9];
    t3 = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h5A, 8'h7E, 8'h81};
    reset = 1'b1; op = NONE; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("txd_reset", 32'(txd), 32'd1);
    chk("busy_reset", 32'(busy), 32'd0);
    mon_quiet = 1'b0;
    bus(LOAD_WORD, BASE + 32'h4, '0, 32'h4, 1'b0, "status_reset");
    bus(LOAD_WORD, BASE + 32'h8, '0, 32'h4, 1'b0, "div_reset");
    bus(LOAD_WORD, BASE,         '0, 32'h0, 1'b0, "txdata_read");

    // Single frame 0xA5 at P=4
    bus(STORE_WORD, BASE + 32'h8, 32'd4, '0, 1'b0, "div_wr4");
    bus(STORE_WORD, BASE, 32'h0000_00A5, '0, 1'b0, "store_a5");
    n = last_cyc;
    fq.push_back(mk(8'hA5, 1'b0, n + 2, 10, 4, 4));
    bus(LOAD_WORD, BASE + 32'h4, '0, 32'h0000_0100, 1'b0, "status_after_push");
    wait_until(n + 10);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    wait_until(n + 45);
    chk("busy_after_frame", 32'(busy), 32'd0);
    bus(LOAD_WORD, BASE + 32'h4, '0, 32'h4, 1'b0, "status_after_frame");

    // Nine back-to-back bytes at P=16, tenth overflows
    bus(STORE_WORD, BASE + 32'h8, 32'd16, '0, 1'b0, "div_wr16");
    for (int i = 0; i < 9; i++) begin
      bus(STORE_WORD, BASE, {24'h0, t3[i]}, '0, 1'b0, "store_burst");
      if (i == 0) n = last_cyc;
      fq.push_back(mk(t3[i], i != 0, (i == 0) ? n + 2 : 0, 10, 16, 16));
    end
    bus(STORE_WORD, BASE, 32'h0000_00EE, '0, 1'b0, "store_overflow");
    bus(LOAD_WORD, BASE + 32'h4, '0, 32'h0000_080B, 1'b0, "status_full_ovf");
    bus(STORE_WORD, BASE + 32'h4, 32'h8, '0, 1'b0, "clear_ovf");
    bus(LOAD_WORD, BASE + 32'h4, '0, 32'h0000_0803, 1'b0, "status_ovf_cleared");
    wait_until(n + 1460);
    bus(LOAD_WORD, BASE + 32'h4, '0, 32'h4, 1'b0, "status_burst_done");

    // Divisor change during the start bit
    bus(STORE_WORD, BASE, 32'h0000_000F, '0, 1'b0, "store_0f");
    n = last_cyc;
    fq.push_back(mk(8'h0F, 1'b0, n + 2, 10, 16, 8));
    repeat (3) @(negedge clk);
    bus(STORE_WORD, BASE + 32'h8, 32'd8, '0, 1'b0, "div_wr8_mid");
    wait_until(n + 100);
    bus(LOAD_WORD, BASE + 32'h8, '0, 32'd8, 1'b0, "div_read8");

    // Error and out-of-window accesses
    bus(STORE_WORD, BASE + 32'hC,  32'hFF, '0, 1'b1, "err_off3");
    bus(STORE_BYTE, BASE,          32'h41, '0, 1'b1, "err_byte");
    bus(STORE_WORD, BASE + 32'h2,  32'h42, '0, 1'b1, "err_misalign_st");
    bus(LOAD_WORD,  BASE + 32'h6,  '0,     '0, 1'b1, "err_misalign_ld");
    bus(LOAD_WORD,  BASE + 32'h4,  '0,  32'h4, 1'b0, "status_after_err");
    bus(STORE_WORD, BASE + 32'h18, 32'h3,  '0, 1'b0, "miss_store_div");
    bus(STORE_WORD, BASE + 32'h10, 32'h44, '0, 1'b0, "miss_store_tx");
    bus(LOAD_WORD,  BASE + 32'h14, '0,     '0, 1'b0, "miss_load");
    bus(LOAD_WORD,  BASE + 32'h8,  '0,  32'd8, 1'b0, "div_after_err");
    bus(LOAD_WORD,  BASE + 32'h4,  '0,  32'h4, 1'b0, "status_after_miss");

    // Reset during data bit 3 of 0x96 (bit 3 = 0)
    bus(STORE_WORD, BASE + 32'h8, 32'd4, '0, 1'b0, "div_wr4b");
    bus(STORE_WORD, BASE, 32'h0000_0096, '0, 1'b0, "store_96");
    n = last_cyc;
    fq.push_back(mk(8'h96, 1'b0, n + 2, 4, 4, 4));
    bus(STORE_WORD, BASE, 32'h0000_0011, '0, 1'b0, "store_11");
    bus(STORE_WORD, BASE, 32'h0000_0022, '0, 1'b0, "store_22");
    wait_until(n + 10);
    mon_quiet = 1'b1;
    wait_until(n + 19);
    chk("txd_bit3", 32'(txd), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("txd_after_reset", 32'(txd), 32'd1);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    chk("txd_quiet_after_reset", 32'(bad), 32'd0);
    bus(LOAD_WORD, BASE + 32'h4, '0, 32'h4, 1'b0, "status_after_reset");
    bus(LOAD_WORD, BASE + 32'h8, '0, 32'h4, 1'b0, "div_after_reset");
    repeat (2) @(negedge clk);
    mon_quiet = 1'b0;
    repeat (5) @(negedge clk);

    chk("frames_pending", 32'(fq.size()), 32'd0);
    chk("bus_pending", 32'(bq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
